// File: rtl/obj_pkg.sv
// Shared definitions for the OBJ scanline writer: OAM attribute bit positions,
// buffer word layout, FSM states and the shape/size lookup.
package obj_pkg;

    localparam int A0_Y_LSB     = 0;
    localparam int A0_AFFINE    = 8;
    localparam int A0_DISABLE   = 9;
    localparam int A0_MODE_LSB  = 10;
    localparam int A0_MOSAIC    = 12;
    localparam int A0_BPP8      = 13;
    localparam int A0_SHAPE_LSB = 14;

    localparam int A1_X_LSB     = 0;
    localparam int A1_HFLIP     = 12;
    localparam int A1_VFLIP     = 13;
    localparam int A1_SIZE_LSB  = 14;

    localparam int A2_TILE_LSB  = 0;
    localparam int A2_PRIO_LSB  = 10;
    localparam int A2_PAL_LSB   = 12;

    localparam int WD_IDX_LSB   = 0;
    localparam int WD_PRIO_LSB  = 8;
    localparam int WD_WINDOW    = 14;
    localparam int WD_SEMI      = 15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_OAM_RD,
        ST_EVAL,
        ST_PIX,
        ST_NEXT,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic       ok;
        logic [6:0] w;
        logic [6:0] h;
    } obj_dim_t;

    // Sprite fields still needed once the pixel loop starts.
    typedef struct packed {
        logic [8:0] x;
        logic       hflip;
        logic       vflip;
        logic       bpp8;
        logic [1:0] mode;
        logic [9:0] tile;
        logic [1:0] prio;
        logic [3:0] pal;
    } obj_attr_t;

    function automatic obj_dim_t size_lut(input logic [1:0] shape, input logic [1:0] size);
        obj_dim_t d;
        d.ok = 1'b1;
        d.w  = 7'd8;
        d.h  = 7'd8;
        case (shape)
            2'b00: begin
                d.w = 7'd8 << size;
                d.h = 7'd8 << size;
            end
            2'b01, 2'b10: begin
                case (size)
                    2'd0:    begin d.w = 7'd16; d.h = 7'd8;  end
                    2'd1:    begin d.w = 7'd32; d.h = 7'd8;  end
                    2'd2:    begin d.w = 7'd32; d.h = 7'd16; end
                    default: begin d.w = 7'd64; d.h = 7'd32; end
                endcase
                if (shape == 2'b10) begin
                    d.w = d.h;
                    d.h = (size == 2'd0) ? 7'd16 : (size == 2'd3) ? 7'd64 : 7'd32;
                end
            end
            default: d.ok = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/obj_row_writer_if.sv
// Bus bundle between the OBJ row writer, its OAM/VRAM memories and the row buffer.
interface obj_row_writer_if;
    logic [6:0]  oam_addr;
    logic [47:0] oam_rdata;
    logic [14:0] vram_addr;
    logic [7:0]  vram_rdata;
    logic [7:0]  buf_row;
    logic [7:0]  wcol;
    logic [19:0] wdata;
    logic        we;
    logic        clear;
    logic        transparent;
    logic        palettemode;
    logic        busy;
    logic        done;

    modport master (
        output oam_addr, input oam_rdata,
        output vram_addr, input vram_rdata,
        output buf_row, wcol, wdata, we, clear, transparent, palettemode, busy, done
    );

    modport slave (
        input oam_addr, output oam_rdata,
        input vram_addr, output vram_rdata,
        input buf_row, wcol, wdata, we, clear, transparent, palettemode, busy, done
    );
endinterface

// File: rtl/obj_tile_addr.sv
// Combinational tile fetch address for one sprite pixel, plus decode of the
// returned VRAM byte into a colour index and transparency flag.
module obj_tile_addr (
    input  logic        bpp8_i,
    input  logic        hflip_i,
    input  logic        vflip_i,
    input  logic        obj_1d_i,
    input  logic [9:0]  tile_i,
    input  logic [3:0]  pal_i,
    input  logic [6:0]  w_i,
    input  logic [6:0]  h_i,
    input  logic [6:0]  px_i,
    input  logic [5:0]  dy_i,
    input  logic [7:0]  byte_i,
    input  logic        hi_nib_i,
    output logic [14:0] vram_addr_o,
    output logic        sx0_o,
    output logic [7:0]  idx_o,
    output logic        transparent_o
);
    logic [5:0] sx, sy, stride, off;
    logic [9:0] ty_term, tx_term, u;
    logic [3:0] nib;

    assign sx = hflip_i ? 6'(w_i - 7'd1 - px_i) : px_i[5:0];
    assign sy = vflip_i ? 6'(h_i - 7'd1 - {1'b0, dy_i}) : dy_i;

    assign stride  = obj_1d_i ? (bpp8_i ? {1'b0, w_i[6:3], 1'b0} : {2'b00, w_i[6:3]}) : 6'd32;
    assign ty_term = 10'({7'b0, sy[5:3]} * {4'b0, stride});
    assign tx_term = bpp8_i ? {6'b0, sx[5:3], 1'b0} : {7'b0, sx[5:3]};
    // Only u mod 1024 matters: u*32 wraps at the 32 KB VRAM boundary.
    assign u       = tile_i + ty_term + tx_term;
    assign off     = bpp8_i ? ({sy[2:0], 3'b000} + {3'b000, sx[2:0]})
                            : ({1'b0, sy[2:0], 2'b00} + {4'b0000, sx[2:1]});

    assign vram_addr_o   = {u, 5'b00000} + {9'b0, off};
    assign sx0_o         = sx[0];
    assign nib           = hi_nib_i ? byte_i[7:4] : byte_i[3:0];
    assign idx_o         = bpp8_i ? byte_i : {pal_i, nib};
    assign transparent_o = bpp8_i ? (byte_i == 8'h00) : (nib == 4'h0);
endmodule

// File: rtl/obj_row_writer.sv
// Per-scanline OBJ rasterizer: clears the target row, scans OAM in order and
// streams one buffer write per pixel of every sprite that covers the line.
module obj_row_writer
    import obj_pkg::*;
#(
    parameter int NUM_OBJ  = 128,
    parameter int SCREEN_W = 240
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [7:0]       row,
    input  logic             obj_1d,
    obj_row_writer_if.master bus
);
    localparam logic [7:0] LAST_OBJ   = 8'(NUM_OBJ - 1);
    localparam logic [9:0] SCREEN_W10 = 10'(SCREEN_W);

    state_e     state_q, state_d;
    logic [7:0] n_q, n_d, row_q, row_d, wcol_q, wcol_d;
    obj_attr_t  attr_q, attr_d;
    logic [6:0] w_q, w_d, h_q, h_d, px_q, px_d;
    logic [5:0] dy_q, dy_d;
    logic       wr_q, wr_d, we_q, we_d, hi_q, hi_d;

    logic [15:0] oam_a0, oam_a1, oam_a2;
    obj_dim_t    dim;
    logic [7:0]  dy_raw, pix_idx;
    logic [9:0]  col;
    logic [14:0] pix_addr;
    logic        skip, sx0, pix_tr, unused_attr_bits;
    logic [19:0] wdata_c;

    assign oam_a0 = bus.oam_rdata[15:0];
    assign oam_a1 = bus.oam_rdata[31:16];
    assign oam_a2 = bus.oam_rdata[47:32];
    assign unused_attr_bits = ^{oam_a0[A0_MOSAIC], oam_a1[11:9]};

    assign dim    = size_lut(oam_a0[A0_SHAPE_LSB +: 2], oam_a1[A1_SIZE_LSB +: 2]);
    assign dy_raw = row_q - oam_a0[A0_Y_LSB +: 8];
    assign skip   = oam_a0[A0_AFFINE] | oam_a0[A0_DISABLE] | (oam_a0[A0_MODE_LSB +: 2] == 2'b11)
                  | ~dim.ok | (dy_raw >= {1'b0, dim.h});
    assign col    = {attr_q.x[8], attr_q.x} + {3'b000, px_q};

    obj_tile_addr u_tile_addr (
        .bpp8_i        (attr_q.bpp8),
        .hflip_i       (attr_q.hflip),
        .vflip_i       (attr_q.vflip),
        .obj_1d_i      (obj_1d),
        .tile_i        (attr_q.tile),
        .pal_i         (attr_q.pal),
        .w_i           (w_q),
        .h_i           (h_q),
        .px_i          (px_q),
        .dy_i          (dy_q),
        .byte_i        (bus.vram_rdata),
        .hi_nib_i      (hi_q),
        .vram_addr_o   (pix_addr),
        .sx0_o         (sx0),
        .idx_o         (pix_idx),
        .transparent_o (pix_tr)
    );

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        row_d   = row_q;
        attr_d  = attr_q;
        w_d     = w_q;
        h_d     = h_q;
        dy_d    = dy_q;
        px_d    = px_q;
        wr_d    = 1'b0;
        we_d    = 1'b0;
        wcol_d  = wcol_q;
        hi_d    = hi_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    row_d   = row;
                    n_d     = '0;
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR:  state_d = ST_OAM_RD;
            ST_OAM_RD: state_d = ST_EVAL;
            ST_EVAL: begin
                if (skip) begin
                    state_d = ST_NEXT;
                end else begin
                    attr_d.x     = oam_a1[A1_X_LSB +: 9];
                    attr_d.hflip = oam_a1[A1_HFLIP];
                    attr_d.vflip = oam_a1[A1_VFLIP];
                    attr_d.bpp8  = oam_a0[A0_BPP8];
                    attr_d.mode  = oam_a0[A0_MODE_LSB +: 2];
                    attr_d.tile  = oam_a2[A2_TILE_LSB +: 10];
                    attr_d.prio  = oam_a2[A2_PRIO_LSB +: 2];
                    attr_d.pal   = oam_a2[A2_PAL_LSB +: 4];
                    w_d          = dim.w;
                    h_d          = dim.h;
                    dy_d         = dy_raw[5:0];
                    px_d         = '0;
                    state_d      = ST_PIX;
                end
            end
            ST_PIX: begin
                // Address goes out now; the write for this pixel lands next cycle.
                wr_d   = 1'b1;
                we_d   = ~col[9] && (col < SCREEN_W10);
                wcol_d = col[7:0];
                hi_d   = sx0;
                px_d   = px_q + 7'd1;
                if (px_q == w_q - 7'd1) state_d = ST_NEXT;
            end
            ST_NEXT: begin
                n_d     = n_q + 8'd1;
                state_d = (n_q == LAST_OBJ) ? ST_DONE : ST_OAM_RD;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            n_q     <= '0;
            row_q   <= '0;
            attr_q  <= '0;
            w_q     <= '0;
            h_q     <= '0;
            dy_q    <= '0;
            px_q    <= '0;
            wr_q    <= 1'b0;
            we_q    <= 1'b0;
            wcol_q  <= '0;
            hi_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            row_q   <= row_d;
            attr_q  <= attr_d;
            w_q     <= w_d;
            h_q     <= h_d;
            dy_q    <= dy_d;
            px_q    <= px_d;
            wr_q    <= wr_d;
            we_q    <= we_d;
            wcol_q  <= wcol_d;
            hi_q    <= hi_d;
        end
    end

    always_comb begin
        wdata_c = '0;
        if (wr_q) begin
            wdata_c[WD_IDX_LSB +: 8]  = pix_idx;
            wdata_c[WD_PRIO_LSB +: 2] = attr_q.prio;
            wdata_c[WD_WINDOW]        = (attr_q.mode == 2'b10);
            wdata_c[WD_SEMI]          = (attr_q.mode == 2'b01);
        end
    end

    assign bus.oam_addr    = n_q[6:0];
    assign bus.vram_addr   = (state_q == ST_PIX) ? pix_addr : '0;
    assign bus.buf_row     = row_q;
    assign bus.wcol        = wcol_q;
    assign bus.wdata       = wdata_c;
    assign bus.we          = we_q;
    assign bus.clear       = (state_q == ST_CLEAR);
    assign bus.transparent = wr_q & pix_tr;
    assign bus.palettemode = attr_q.bpp8;
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.done        = (state_q == ST_DONE);
endmodule

// File: tb/tb_obj_row_writer.sv
// Scoreboard bench for obj_row_writer: directed sprite setups push expected
// buffer writes; a monitor pops and compares on every write strobe.
module tb_obj_row_writer;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       obj_1d = 1'b0;
    logic [7:0] row = 8'd0;

    obj_row_writer_if bus ();

    obj_row_writer #(.NUM_OBJ(128), .SCREEN_W(240)) dut (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .row    (row),
        .obj_1d (obj_1d),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    logic [47:0] oam_mem  [128];
    logic [7:0]  vram_mem [32768];

    always @(posedge clock) begin
        bus.oam_rdata  <= oam_mem[bus.oam_addr];
        bus.vram_rdata <= vram_mem[bus.vram_addr];
    end

    typedef struct packed {
        logic [7:0]  col;
        logic [19:0] wd;
        logic        tr;
        logic        pm;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int n_cmp = 0, n_err = 0;
    int clear_cnt = 0, done_cnt = 0, wr_cnt = 0;

    initial begin
        forever begin
            @(negedge clock);
            if (!reset) begin
                if (bus.clear) clear_cnt++;
                if (bus.done)  done_cnt++;
                if (bus.we) begin
                    wr_cnt++;
                    n_cmp++;
                    if (sbq.size() == 0) begin
                        n_err++;
                        $display("FAIL extra_write: got col=%0d wdata=%05h, want no write", bus.wcol, bus.wdata);
                    end else begin
                        mon_e = sbq.pop_front();
                        if (bus.wcol !== mon_e.col || bus.wdata !== mon_e.wd ||
                            bus.transparent !== mon_e.tr || bus.palettemode !== mon_e.pm) begin
                            n_err++;
                            $display("FAIL write: got col=%0d wdata=%05h tr=%0b pm=%0b, want col=%0d wdata=%05h tr=%0b pm=%0b",
                                     bus.wcol, bus.wdata, bus.transparent, bus.palettemode,
                                     mon_e.col, mon_e.wd, mon_e.tr, mon_e.pm);
                        end
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic wipe();
        for (int i = 0; i < 128; i++) oam_mem[i] = 48'h0000_0000_0200;
        for (int i = 0; i < 32768; i++) vram_mem[i] = 8'h00;
    endtask

    // 8x8 4bpp tile 4, line 2: nibbles for sx 0..7 are 1,2,3,4,5,6,7,0.
    task automatic set_tile4();
        vram_mem[136] = 8'h21;
        vram_mem[137] = 8'h43;
        vram_mem[138] = 8'h65;
        vram_mem[139] = 8'h07;
    endtask

    task automatic push(input int col, input logic [19:0] wd, input logic tr, input logic pm);
        exp_t e;
        e.col = 8'(col);
        e.wd  = wd;
        e.tr  = tr;
        e.pm  = pm;
        if (col >= 0 && col < 240) sbq.push_back(e);
    endtask

    task automatic push_row8(input int col0, input logic [19:0] base, input bit hflip);
        int sx, nib;
        for (int px = 0; px < 8; px++) begin
            sx  = hflip ? 7 - px : px;
            nib = (sx == 7) ? 0 : sx + 1;
            push(col0 + px, base | 20'(8'h30 | 8'(nib)), (nib == 0), 1'b0);
        end
    endtask

    task automatic render(input logic [7:0] r, input bit one_d, input bit poke, input string tag);
        bit got_done;
        clear_cnt = 0;
        done_cnt  = 0;
        wr_cnt    = 0;
        got_done  = 0;
        @(negedge clock);
        row    = r;
        obj_1d = one_d;
        start  = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int cyc = 0; cyc < 4000 && !got_done; cyc++) begin
            if (poke && cyc == 20) begin
                start = 1'b1;
                row   = 8'd99;
            end else if (poke && cyc == 21) begin
                start = 1'b0;
                row   = r;
            end
            @(negedge clock);
            if (bus.done) got_done = 1;
        end
        chk({tag, "_done_seen"}, 32'(got_done), 32'd1);
        @(negedge clock);
        chk({tag, "_busy_after"}, 32'(bus.busy), 32'd0);
        chk({tag, "_clear_cycles"}, clear_cnt, 32'd1);
        chk({tag, "_done_pulses"}, done_cnt, 32'd1);
        chk({tag, "_missing_writes"}, sbq.size(), 32'd0);
        chk({tag, "_buf_row"}, 32'(bus.buf_row), 32'(r));
        $display("render %s row=%0d writes=%0d", tag, r, wr_cnt);
        sbq.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit we_seen;
        wipe();
        repeat (3) @(negedge clock);
        reset = 1'b0;
        chk("rst_busy",     32'(bus.busy),        32'd0);
        chk("rst_done",     32'(bus.done),        32'd0);
        chk("rst_we",       32'(bus.we),          32'd0);
        chk("rst_clear",    32'(bus.clear),       32'd0);
        chk("rst_buf_row",  32'(bus.buf_row),     32'd0);
        chk("rst_wcol",     32'(bus.wcol),        32'd0);
        chk("rst_wdata",    32'(bus.wdata),       32'd0);
        chk("rst_oam_addr", 32'(bus.oam_addr),    32'd0);
        chk("rst_vram",     32'(bus.vram_addr),   32'd0);
        chk("rst_transp",   32'(bus.transparent), 32'd0);
        chk("rst_palmode",  32'(bus.palettemode), 32'd0);

        render(8'd10, 1'b0, 1'b0, "all_disabled");

        wipe(); set_tile4();
        oam_mem[0] = {16'h3004, 16'h0005, 16'h000A};
        push_row8(5, 20'h00000, 1'b0);
        render(8'd12, 1'b0, 1'b1, "basic_start_ignored");

        wipe(); set_tile4();
        oam_mem[0] = {16'h3004, 16'h1005, 16'h000A};
        push_row8(5, 20'h00000, 1'b1);
        render(8'd12, 1'b0, 1'b0, "hflip");

        wipe(); set_tile4();
        oam_mem[0] = {16'h3004, 16'h01FC, 16'h000A};
        push_row8(-4, 20'h00000, 1'b0);
        render(8'd12, 1'b0, 1'b0, "clip_left");

        wipe(); set_tile4();
        oam_mem[0] = {16'h3004, 16'h00EC, 16'h000A};
        push_row8(236, 20'h00000, 1'b0);
        render(8'd12, 1'b0, 1'b0, "clip_right");

        wipe(); set_tile4();
        oam_mem[0] = {16'h3804, 16'h0005, 16'h080A};
        push_row8(5, 20'h04200, 1'b0);
        render(8'd12, 1'b0, 1'b0, "window_prio2");

        wipe(); set_tile4();
        oam_mem[0] = {16'h3004, 16'h0005, 16'h040A};
        push_row8(5, 20'h08000, 1'b0);
        render(8'd12, 1'b0, 1'b0, "semi_transparent");

        wipe(); set_tile4();
        oam_mem[0] = {16'h3004, 16'h0005, 16'h010A};
        oam_mem[1] = {16'h3004, 16'h0005, 16'h0C0A};
        oam_mem[2] = {16'h3004, 16'h0005, 16'h000A};
        oam_mem[3] = {16'h3004, 16'h0005, 16'h0000};
        oam_mem[4] = {16'h3004, 16'h0005, 16'hC00A};
        oam_mem[5] = {16'h3004, 16'h0064, 16'h000A};
        push_row8(5, 20'h00000, 1'b0);
        push_row8(100, 20'h00000, 1'b0);
        render(8'd12, 1'b0, 1'b0, "skips_and_order");

        // 16x16 8bpp at y=250 on row 3: dy=9, pixel (0,9) at byte 1032 in 2D mapping.
        wipe();
        oam_mem[0] = {16'h0000, 16'h4000, 16'h20FA};
        vram_mem[1032] = 8'h5A;
        vram_mem[1033] = 8'hA5;
        vram_mem[1096] = 8'h11;
        vram_mem[1103] = 8'hFF;
        for (int px = 0; px < 16; px++) begin
            case (px)
                0:       push(px, 20'h0005A, 1'b0, 1'b1);
                1:       push(px, 20'h000A5, 1'b0, 1'b1);
                8:       push(px, 20'h00011, 1'b0, 1'b1);
                15:      push(px, 20'h000FF, 1'b0, 1'b1);
                default: push(px, 20'h00000, 1'b1, 1'b1);
            endcase
        end
        render(8'd3, 1'b0, 1'b0, "bpp8_2d_wrap");

        // Same sprite in 1D mapping: stride 4 units, bytes 136 and 200 for px 0 and 8.
        wipe();
        oam_mem[0] = {16'h0000, 16'h4000, 16'h20FA};
        vram_mem[136] = 8'h77;
        vram_mem[200] = 8'h88;
        vram_mem[207] = 8'h01;
        for (int px = 0; px < 16; px++) begin
            case (px)
                0:       push(px, 20'h00077, 1'b0, 1'b1);
                8:       push(px, 20'h00088, 1'b0, 1'b1);
                15:      push(px, 20'h00001, 1'b0, 1'b1);
                default: push(px, 20'h00000, 1'b1, 1'b1);
            endcase
        end
        render(8'd3, 1'b1, 1'b0, "bpp8_1d");

        wipe(); set_tile4();
        oam_mem[0] = {16'h3004, 16'h0005, 16'h000A};
        push_row8(5, 20'h00000, 1'b0);
        @(negedge clock);
        row   = 8'd12;
        start = 1'b1;
        @(negedge clock);
        start   = 1'b0;
        we_seen = 0;
        for (int cyc = 0; cyc < 200 && !we_seen; cyc++) begin
            @(negedge clock);
            if (bus.we) we_seen = 1;
        end
        chk("midpix_we_seen", 32'(we_seen), 32'd1);
        reset = 1'b1;
        #1;
        chk("midpix_we_dropped", 32'(bus.we),    32'd0);
        chk("midpix_busy",       32'(bus.busy),  32'd0);
        chk("midpix_clear",      32'(bus.clear), 32'd0);
        sbq.delete();
        repeat (2) @(negedge clock);
        reset    = 1'b0;
        done_cnt = 0;
        clear_cnt = 0;
        repeat (30) @(negedge clock);
        chk("post_reset_busy",  32'(bus.busy), 32'd0);
        chk("post_reset_done",  done_cnt,      32'd0);
        chk("post_reset_clear", clear_cnt,     32'd0);
        $display("reset mid-render checked");

        push_row8(5, 20'h00000, 1'b0);
        render(8'd12, 1'b0, 1'b0, "recover");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/obj_row_writer.md
Name: obj_row_writer

Overview:
- Per-scanline OBJ rasterizer; the write-side producer for the OBJ row double buffer.
- On each line start it clears the target row, then walks OAM sprites 0..127 in order.
- For every sprite that intersects the line, it fetches tile bytes from OBJ VRAM and emits one wcol/wdata/we write per sprite pixel.
- The buffer only accepts a write into a still-transparent slot, so the lowest-numbered sprite wins.

Parameters:
- NUM_OBJ, 128, number of OAM entries scanned.
- SCREEN_W, 240, visible columns; writes to columns >= SCREEN_W are suppressed.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse: render line `row`
- row  in  8  line to render; sampled on accepted start
- obj_1d  in  1  OBJ tile mapping: 1 = 1D, 0 = 2D
- oam_addr  out  7  sprite index to read
- oam_rdata  in  48  {attr2,attr1,attr0}; valid 1 cycle after oam_addr
- vram_addr  out  15  byte address within 32 KB OBJ VRAM
- vram_rdata  in  8  valid 1 cycle after vram_addr
- buf_row  out  8  row driven to buffer; constant for the whole render
- wcol  out  8  write column
- wdata  out  20  pixel word
- we  out  1  write strobe
- clear  out  1  clear strobe (whole row)
- transparent  out  1  current pixel is colour 0
- palettemode  out  1  1 = 256-colour sprite
- busy  out  1  render in progress
- done  out  1  one-cycle pulse at end of line

Behaviour:
- Reset: all outputs 0; state IDLE.
- Reset mid-render aborts immediately, with no further we/clear.
- start is accepted only in IDLE; start while busy is ignored.
- FSM sequence:
  - IDLE.
  - CLEAR: 1 cycle, clear=1.
  - OAM_RD: oam_addr=n.
  - EVAL: check the attributes.
  - PIX: pipelined pixel loop.
  - NEXT: n++; if n == NUM_OBJ go to DONE, else OAM_RD.
  - DONE: done=1, then IDLE.
  - busy=1 in every state except IDLE.
- EVAL skips the sprite (goes to NEXT) when any of these hold:
  - attr0[8]=1 (affine is unsupported; such sprites are dropped);
  - attr0[9]=1 (disabled);
  - mode attr0[11:10]=11;
  - dy=(row-attr0[7:0]) mod 256 is >= h.
- Size LUT maps {shape attr0[15:14], size attr1[15:14]} to (w,h):
  - square: 8/16/32/64;
  - wide: 16x8, 32x8, 32x16, 64x32;
  - tall: transposed wide;
  - shape 11 → skip.
- PIX loop, px = 0..w-1, throughput 1 pixel/cycle:
  - Cycle c presents vram_addr for px.
  - Cycle c+1 asserts we with wcol/wdata for px.
  - Last write occurs 1 cycle after the last address; NEXT follows.
- Column: x = sign-extended attr1[8:0]; col = x+px (10-bit). we=0 when col<0 or col>=SCREEN_W (pixel cycle still consumed).
- Flip and tile position:
  - sx = attr1[12] ? w-1-px : px; sy = attr1[13] ? h-1-dy : dy.
  - tx=sx>>3, ty=sy>>3.
  - bpp8 = attr0[13] (also drives palettemode).
- Address units (32-byte):
  - u = attr2[9:0] + ty*stride + tx*(bpp8?2:1).
  - stride = obj_1d ? (w/8)*(bpp8?2:1) : 32.
- Byte address: vram_addr = (u*32 + (sy&7)*(bpp8?8:4) + (bpp8 ? (sx&7) : (sx&7)>>1)) mod 32768.
- Pixel index:
  - 4bpp: nibble = sx[0] ? byte[7:4] : byte[3:0]; idx = {attr2[15:12], nibble}.
  - 8bpp: idx = byte.
  - transparent = (nibble==0 | 8bpp byte==0).
- wdata fields:
  - [7:0] idx;
  - [9:8] priority attr2[11:10];
  - [13:10] 0;
  - [14] window (mode 10);
  - [15] semi-transparent (mode 01);
  - [19:16] 0.
- buf_row = row latched at start; held until the next accepted start.

Decomposition:
- Package obj_pkg holds:
  - attr bit-position constants;
  - wdata field positions;
  - state enum;
  - a size_lut function (shape,size → w,h).
- Sub-module obj_tile_addr: combinational address, nibble select and transparent computation from (attrs, px, dy, obj_1d).

Test Plan:
- All 128 sprites disabled (attr0[9]=1), row=10, start → exactly 1 clear cycle, 0 we, done pulse; busy low after.
- Sprite 0: y=10, x=5, 8x8 4bpp, tile 4, palbank 3, row=12; VRAM byte at 4*32+2*4=136 = 0x21 → first write wcol=5 wdata=0x00031, transparent=0; second write wcol=6 wdata=0x00032.
- Same sprite with attr1[12]=1 (hflip) → wcol=5 reads nibble of sx=7; wcol=12 gets idx 0x31.
- x=-4 (attr1[8:0]=0x1FC), 8 wide → we only for wcol 0..3; x=236 → we only for wcol 236..239.
- y=250, h=16, row=3 → dy=9, sprite drawn; 16x16 8bpp, obj_1d=0, tile 0 → pixel (0,9) at vram_addr = 32*32+8 = 1032.
- Mode 10 → wdata[14]=1; attr0=affine → no we for that sprite; reset asserted mid-PIX → we drops within the same cycle, busy=0.
